// File: rtl/core_id_opnd_stage.sv
// core_id_opnd_stage: decode-stage pipeline register with rs1/rs2 operand
// resolution from the register file or NUM_FWD downstream forwarding channels.
// Channel 0 is the youngest producer and wins when several channels match.
// Define CORE_ID_FWD_EN to enable data forwarding; without it the stage runs
// in interlock-only mode and stalls on any matching in-flight producer.
module core_id_opnd_stage #(
    parameter int XLEN        = 32,
    parameter int PC_WIDTH    = 32,
    parameter int INST_WIDTH  = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int NUM_FWD     = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    output logic                           ready_in,
    output logic                           valid_out,
    input  logic                           ready_out,
    input  logic                           i_pipe_flush_req,
    input  logic [PC_WIDTH-1:0]            i_pc,
    input  logic [INST_WIDTH-1:0]          i_inst,
    input  logic                           i_branch_predict,
    input  logic [RFIDX_WIDTH-1:0]         i_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0]         i_rs2_idx,
    input  logic                           i_rs1_ren,
    input  logic                           i_rs2_ren,
    output logic [PC_WIDTH-1:0]            o_pc,
    output logic [INST_WIDTH-1:0]          o_inst,
    output logic                           o_branch_predict,
    output logic [RFIDX_WIDTH-1:0]         o_rs1_idx,
    output logic [RFIDX_WIDTH-1:0]         o_rs2_idx,
    output logic                           o_rs1_ren,
    output logic                           o_rs2_ren,
    input  logic [XLEN-1:0]                rs1_dat,
    input  logic [XLEN-1:0]                rs2_dat,
    input  logic [NUM_FWD*RFIDX_WIDTH-1:0] fwd_idx,
    input  logic [NUM_FWD-1:0]             fwd_wen,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_dat,
    input  logic [NUM_FWD-1:0]             fwd_dat_vld,
    output logic [XLEN-1:0]                o_rs1_dat,
    output logic [XLEN-1:0]                o_rs2_dat,
    output logic                           o_hazard_stall
);

    logic                   v_q, v_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INST_WIDTH-1:0]  inst_q;
    logic                   bp_q;
    logic [RFIDX_WIDTH-1:0] rs1_idx_q, rs2_idx_q;
    logic                   rs1_ren_q, rs2_ren_q;

    logic [NUM_FWD-1:0]     m1, m2;
    logic                   stall1, stall2;
    logic                   capture;

    // Per-channel source match against the held indices; x0 never matches.
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            m1[k] = fwd_wen[k] && (fwd_idx[k*RFIDX_WIDTH +: RFIDX_WIDTH] == rs1_idx_q)
                    && (rs1_idx_q != '0) && rs1_ren_q;
            m2[k] = fwd_wen[k] && (fwd_idx[k*RFIDX_WIDTH +: RFIDX_WIDTH] == rs2_idx_q)
                    && (rs2_idx_q != '0) && rs2_ren_q;
        end
    end

`ifdef CORE_ID_FWD_EN
    logic            hit1, hit2, wvld1, wvld2;
    logic [XLEN-1:0] wdat1, wdat2;

    // Pick the lowest-index matching channel; scanning downward lets it overwrite older ones.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        wvld1 = 1'b1;
        wvld2 = 1'b1;
        wdat1 = '0;
        wdat2 = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (m1[k]) begin
                hit1  = 1'b1;
                wvld1 = fwd_dat_vld[k];
                wdat1 = fwd_dat[k*XLEN +: XLEN];
            end
            if (m2[k]) begin
                hit2  = 1'b1;
                wvld2 = fwd_dat_vld[k];
                wdat2 = fwd_dat[k*XLEN +: XLEN];
            end
        end
    end

    assign stall1    = hit1 & ~wvld1;
    assign stall2    = hit2 & ~wvld2;
    assign o_rs1_dat = hit1 ? wdat1 : rs1_dat;
    assign o_rs2_dat = hit2 ? wdat2 : rs2_dat;
`else
    // Interlock only: any in-flight producer of a source blocks until it retires.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_dat, fwd_dat_vld};
    assign stall1     = |m1;
    assign stall2     = |m2;
    assign o_rs1_dat  = rs1_dat;
    assign o_rs2_dat  = rs2_dat;
`endif

    assign o_hazard_stall = v_q & (stall1 | stall2);
    assign valid_out      = v_q & ~o_hazard_stall & ~i_pipe_flush_req;
    assign ready_in       = ~v_q | (ready_out & ~o_hazard_stall);
    assign capture        = valid_in & ready_in & ~i_pipe_flush_req;

    // Valid next state: flush beats capture, capture beats drain.
    always_comb begin
        v_d = v_q;
        if (i_pipe_flush_req)            v_d = 1'b0;
        else if (capture)                v_d = 1'b1;
        else if (valid_out && ready_out) v_d = 1'b0;
    end

    // Entry valid bit, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= 1'b0;
        else        v_q <= v_d;
    end

    // Entry payload; loads only on capture and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            inst_q    <= '0;
            bp_q      <= 1'b0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            rs1_ren_q <= 1'b0;
            rs2_ren_q <= 1'b0;
        end else if (capture) begin
            pc_q      <= i_pc;
            inst_q    <= i_inst;
            bp_q      <= i_branch_predict;
            rs1_idx_q <= i_rs1_idx;
            rs2_idx_q <= i_rs2_idx;
            rs1_ren_q <= i_rs1_ren;
            rs2_ren_q <= i_rs2_ren;
        end
    end

    assign o_pc             = pc_q;
    assign o_inst           = inst_q;
    assign o_branch_predict = bp_q;
    assign o_rs1_idx        = rs1_idx_q;
    assign o_rs2_idx        = rs2_idx_q;
    assign o_rs1_ren        = rs1_ren_q;
    assign o_rs2_ren        = rs2_ren_q;

endmodule

// File: doc/core_id_opnd_stage.md
# core_id_opnd_stage

Parametrised decode-stage pipeline register with operand resolution for the core pipeline. Captures PC, instruction, branch-prediction bit and pre-decoded source indices from IF, then resolves rs1/rs2 operands from the register file or from a configurable number of downstream forwarding channels. It stalls on producers whose result is not yet available, such as a load still in flight. It sits between IF and EX and supports full valid/ready backpressure and pipeline flush.

## Interface

**Parameters**
- XLEN, 32, data width
- PC_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction width
- RFIDX_WIDTH, 5, register index width
- NUM_FWD, 3, number of forwarding channels; channel 0 is the youngest (EX) and has the highest priority

**Ports**
- clk  in  1  clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  IF has an entry
- ready_in  out  1  stage can accept
- valid_out  out  1  resolved entry available to EX
- ready_out  in  1  EX accepts
- i_pipe_flush_req  in  1  flush held and incoming entries
- i_pc  in  PC_WIDTH  PC of the incoming entry
- i_inst  in  INST_WIDTH  incoming instruction
- i_branch_predict  in  1  IF prediction bit
- i_rs1_idx, i_rs2_idx  in  RFIDX_WIDTH each  pre-decoded source indices
- i_rs1_ren, i_rs2_ren  in  1 each  source read enables
- o_pc, o_inst, o_branch_predict  out  registered copies of the corresponding inputs
- o_rs1_idx, o_rs2_idx  out  RFIDX_WIDTH  registered source indices; also drive the register-file read address
- o_rs1_ren, o_rs2_ren  out  1 each  registered read enables
- rs1_dat, rs2_dat  in  XLEN each  combinational register-file read data
- fwd_idx  in  NUM_FWD*RFIDX_WIDTH  channel k occupies bits [k*RFIDX_WIDTH +: RFIDX_WIDTH]
- fwd_wen  in  NUM_FWD  channel k writes rd
- fwd_dat  in  NUM_FWD*XLEN  forwarded result of channel k
- fwd_dat_vld  in  NUM_FWD  channel k result is ready (0 = load pending)
- o_rs1_dat, o_rs2_dat  out  XLEN each  resolved operands
- o_hazard_stall  out  1  operand-unavailable stall indicator

## Operation

**Held state**
- Registers: one valid bit `v`, plus the PC, instruction, prediction bit, rs indices and rs enables.

**Source match**
- Channel k matches source s when all hold: fwd_wen[k]; fwd_idx[k] == o_rs_s_idx; o_rs_s_idx != 0; o_rs_s_ren.

**Operand selection**
- The lowest-index matching channel wins.
- If no channel matches, the operand is rs_s_dat.
- If the source is not enabled (ren = 0), the operand is still rs_s_dat.

**Stall**
- o_hazard_stall = v & (for either source, the winning channel has fwd_dat_vld = 0).

**Output valid**
- valid_out = v & ~o_hazard_stall & ~i_pipe_flush_req.

**Input ready**
- ready_in = ~v | (ready_out & ~o_hazard_stall).
- ready_in is independent of valid_in.

**Capture**
- Registers load when valid_in & ready_in & ~i_pipe_flush_req.

**Valid next state** (priority order)
1. i_pipe_flush_req → `v` = 0.
2. Capture → `v` = 1.
3. valid_out & ready_out → `v` = 0.
4. Otherwise `v` holds.

**Holding**
- A presented entry holds all outputs stable until it is accepted or flushed.
- Resolved data may change while the entry waits, as downstream channels advance.

## Timing

- Reset values: `v` = 0, valid_out = 0, ready_in = 1. o_pc, o_inst and o_rs*_idx are 0. Enables, o_branch_predict and o_hazard_stall are 0.
- Latency: one cycle from capture to valid_out, provided there is no hazard.
- Throughput: one entry per cycle with ready_out held at 1 and no hazards.
- Operand resolution is combinational from the held indices within the same cycle. There is no registered forwarding.
- Simultaneous accept and capture (v = 1, ready_out = 1, valid_in = 1): the new entry replaces the old one at the edge, and `v` stays 1.
- Flush in the same cycle as valid_in: the input is dropped, and valid_out is 0 in that cycle.
- A flush takes priority over a pending stall.
- Reset asserted mid-operation clears `v` immediately (asynchronously). Stale data registers are not observable.
- An index-0 destination never matches and never causes a stall.

## Configuration

**CORE_ID_FWD_EN defined**
- Forwarding operates as described above.

**CORE_ID_FWD_EN undefined**
- Interlock-only mode.
- fwd_dat is ignored, and operands always come from rs_s_dat.
- Any matching channel asserts o_hazard_stall, regardless of fwd_dat_vld.
- The stall releases only when no channel matches, i.e. once the producer has written back.

## Test plan

- **Back-to-back flow:** reset, then stream 4 entries with valid_in = 1 and ready_out = 1 → valid_out high from cycle 1 onward. o_pc follows 0x0, 0x4, 0x8, 0xC one cycle late, and ready_in stays 1.
- **Forward priority:** held rs1 = x5. Channel 0 and channel 2 both write x5, with dat 0x11 and 0x22, both dat_vld = 1 → o_rs1_dat = 0x11. With only channel 2 matching → 0x22.
- **Load-use stall:** held rs2 = x7; channel 0 writes x7 with dat_vld = 0 for 2 cycles, then dat_vld = 1 with 0xABCD → o_hazard_stall = 1 and valid_out = 0 for 2 cycles. Then valid_out = 1 with o_rs2_dat = 0xABCD; ready_in = 0 throughout the stall.
- **Backpressure:** ready_out = 0 for 3 cycles with an entry held → outputs stable, ready_in = 0. The next entry is captured in the cycle ready_out returns to 1.
- **Flush:** assert i_pipe_flush_req with v = 1 and valid_in = 1 → valid_out = 0 in that cycle, `v` = 0 the next cycle, and the incoming PC is never presented.
- **x0 and interlock mode:** rs1 = x0 with channel 0 writing x0, dat 0x99, dat_vld = 0 → no stall, and o_rs1_dat = rs1_dat. With CORE_ID_FWD_EN undefined, rs1 = x3 matched by channel 1 with dat_vld = 1 → stall until channel 1 clears.
